register_file: RTL and testbench

//   General-purpose register file for the RISC CPU datapath: 2^M registers of N bits.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/register_file_read_mux.sv | 14 +
 rtl/register_file.sv | 70 +++++++
 tb/tb_register_file.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Widths and types shared by the CPU datapath blocks (ALU, decoder, register file).
`timescale 1ns/1ps
package cpu_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_read_mux.sv
// Combinational 2^M:1 selector of one N-bit register; shared by the read and inspection ports.
`timescale 1ns/1ps
module register_file_read_mux #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 3
) (
    input  logic [N-1:0] regs [0:(2**M)-1],
    input  logic [M-1:0] sel,
    output logic [N-1:0] data
);

    assign data = regs[sel];

endmodule

// File: rtl/register_file.sv
// General-purpose register file: one synchronous write port, two combinational read ports
// and a gated combinational inspection port.
`timescale 1ns/1ps
module register_file
    import cpu_pkg::*;
#(
    parameter int unsigned N = DATA_W,
    parameter int unsigned M = REG_ADDR_W
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         Reg_Write,
    input  logic [M-1:0] Reg_write_ad,
    input  logic [N-1:0] Reg_write_data,
    input  logic [M-1:0] Reg_read_ad_1,
    input  logic [M-1:0] Reg_read_ad_2,
    output logic [N-1:0] Reg_read_data_1,
    output logic [N-1:0] Reg_read_data_2,
    input  logic         inr_check,
    input  logic [M-1:0] inr,
    output logic [N-1:0] outvalue
);

    localparam int unsigned NumRegs = 2 ** M;

    logic [N-1:0] regs [0:NumRegs-1];
    logic [N-1:0] inspect_data;

    // Register 0 is ordinary storage, not hardwired to zero.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (Reg_Write) begin
            regs[Reg_write_ad] <= Reg_write_data;
        end
    end

    // No write-to-read bypass: reads see the old value until the capturing edge.
    register_file_read_mux #(
        .N (N),
        .M (M)
    ) u_read_mux_1 (
        .regs (regs),
        .sel  (Reg_read_ad_1),
        .data (Reg_read_data_1)
    );

    register_file_read_mux #(
        .N (N),
        .M (M)
    ) u_read_mux_2 (
        .regs (regs),
        .sel  (Reg_read_ad_2),
        .data (Reg_read_data_2)
    );

    register_file_read_mux #(
        .N (N),
        .M (M)
    ) u_inspect_mux (
        .regs (regs),
        .sel  (inr),
        .data (inspect_data)
    );

    assign outvalue = inr_check ? inspect_data : '0;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expectations.
`timescale 1ns/1ps
module tb_register_file;
    import cpu_pkg::*;

    logic      Clock = 1'b0;
    logic      Reset_n;
    logic      Reg_Write;
    reg_addr_t Reg_write_ad;
    data_t     Reg_write_data;
    reg_addr_t Reg_read_ad_1;
    reg_addr_t Reg_read_ad_2;
    data_t     Reg_read_data_1;
    data_t     Reg_read_data_2;
    logic      inr_check;
    reg_addr_t inr;
    data_t     outvalue;

    int total = 0;
    int bad   = 0;

    register_file dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .Reg_Write       (Reg_Write),
        .Reg_write_ad    (Reg_write_ad),
        .Reg_write_data  (Reg_write_data),
        .Reg_read_ad_1   (Reg_read_ad_1),
        .Reg_read_ad_2   (Reg_read_ad_2),
        .Reg_read_data_1 (Reg_read_data_1),
        .Reg_read_data_2 (Reg_read_data_2),
        .inr_check       (inr_check),
        .inr             (inr),
        .outvalue        (outvalue)
    );

    // First rising edge at t=5, period 10.
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input data_t observed, input data_t expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        // Test 1: reset held; write inputs already presented but must be ignored.
        Reset_n        = 1'b0;
        inr_check      = 1'b1;
        inr            = '0;
        Reg_Write      = 1'b1;
        Reg_write_ad   = 3'd0;
        Reg_write_data = 16'd20;
        Reg_read_ad_1  = 3'd0;
        Reg_read_ad_2  = 3'd7;
        for (int i = 0; i < 8; i++) begin
            inr = reg_addr_t'(i);
            #0.5;
            check($sformatf("reset_inspect_%0d", i), outvalue, 16'h0000);
        end
        check("reset_rd1", Reg_read_data_1, 16'h0000);
        check("reset_rd2", Reg_read_data_2, 16'h0000);
        Reset_n = 1'b1;                       // t=4, before first edge

        // Test 2: writes captured at t=5, 15, 25.
        #5;                                   // t=9
        Reg_write_ad   = 3'd1;
        Reg_write_data = 16'd10;
        #9;                                   // t=18
        Reg_write_ad   = 3'd5;
        Reg_write_data = 16'd30;
        #5;                                   // t=23
        inr = 3'd0;
        #1 check("inspect_r0", outvalue, 16'd20);
        #4 inr = 3'd1;                        // t=28
        #1 check("inspect_r1", outvalue, 16'd10);
        #4 inr = 3'd5;                        // t=33
        #1 check("inspect_r5", outvalue, 16'd30);
        Reg_read_ad_1 = 3'd0;
        Reg_read_ad_2 = 3'd5;
        #0.5;
        check("rd1_r0", Reg_read_data_1, 16'd20);
        check("rd2_r5", Reg_read_data_2, 16'd30);

        // Test 3: write disabled across three edges.
        Reg_Write      = 1'b0;
        Reg_write_ad   = 3'd2;
        Reg_write_data = 16'hBEEF;
        repeat (3) @(posedge Clock);
        #1 Reg_read_ad_1 = 3'd2;
        #1 check("wr_disabled_r2", Reg_read_data_1, 16'h0000);

        // Test 4: read-during-write returns the old value until the edge.
        Reg_Write      = 1'b1;
        Reg_write_ad   = 3'd3;
        Reg_write_data = 16'd7;
        @(posedge Clock);
        #1;
        Reg_write_data = 16'd9;
        Reg_read_ad_1  = 3'd3;
        Reg_read_ad_2  = 3'd3;
        #1;
        check("rdw_before_p1", Reg_read_data_1, 16'd7);
        check("rdw_before_p2", Reg_read_data_2, 16'd7);
        @(posedge Clock);
        #1;
        Reg_Write = 1'b0;
        check("rdw_after_p1", Reg_read_data_1, 16'd9);
        check("rdw_after_p2", Reg_read_data_2, 16'd9);

        // Test 5: inspection gate.
        inr       = 3'd3;
        inr_check = 1'b0;
        #1 check("gate_off", outvalue, 16'h0000);
        inr_check = 1'b1;
        #1 check("gate_on", outvalue, 16'd9);

        // Test 6: fill, async reset between edges, then a single write.
        Reg_Write      = 1'b1;
        Reg_write_data = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            Reg_write_ad = reg_addr_t'(i);
            @(posedge Clock);
            #1;
        end
        Reg_Write = 1'b0;
        inr       = 3'd0;
        #1 check("fill_r0", outvalue, 16'hFFFF);
        inr = 3'd7;
        #1 check("fill_r7", outvalue, 16'hFFFF);
        Reset_n = 1'b0;                       // 3 ns after an edge
        #0.5;
        for (int i = 0; i < 8; i++) begin
            inr           = reg_addr_t'(i);
            Reg_read_ad_1 = reg_addr_t'(i);
            Reg_read_ad_2 = reg_addr_t'(7 - i);
            #0.5;
            check($sformatf("async_rst_inspect_%0d", i), outvalue, 16'h0000);
            check($sformatf("async_rst_rd1_%0d", i), Reg_read_data_1, 16'h0000);
            check($sformatf("async_rst_rd2_%0d", i), Reg_read_data_2, 16'h0000);
        end
        #0.5;
        Reset_n        = 1'b1;
        Reg_Write      = 1'b1;
        Reg_write_ad   = 3'd7;
        Reg_write_data = 16'h1234;
        @(posedge Clock);
        #1;
        Reg_Write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            inr = reg_addr_t'(i);
            #1;
            check($sformatf("post_rst_r%0d", i), outvalue, (i == 7) ? 16'h1234 : 16'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
